// File: rtl/eink_frame_sched.sv
// rtl/eink_frame_sched.sv - e-ink panel update frame scheduler
// Sequences power-up, per-frame start/wait/gap across phases, and power-down.
module eink_frame_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_frames,
    input  logic [3:0]       req_phases,
    input  logic [CNT_W-1:0] pwr_on_dly,
    input  logic [CNT_W-1:0] pwr_off_dly,
    input  logic [CNT_W-1:0] frame_gap,
    input  logic [CNT_W-1:0] frame_timeout,
    input  logic             abort,
    input  logic             frame_done,
    output logic             frame_fresh,
    output logic             pwr_en,
    output logic [3:0]       phase_idx,
    output logic [7:0]       frame_idx,
    output logic             busy,
    output logic             upd_done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, PWR_UP, START, WAIT_DONE, GAP, PWR_DOWN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_nx;
    logic [7:0]       frames_q, frames_d, frame_q, frame_d;
    logic [3:0]       phases_q, phases_d, phase_q, phase_d;
    logic [CNT_W-1:0] on_q, on_d, off_q, off_d, gap_q, gap_d, tmo_q, tmo_d;
    logic             err_q, err_d, upd_done_q, upd_done_d;
    logic             req_ready_q, busy_q, pwr_en_q, frame_fresh_q;

    // Cycle count including the current cycle; a zero delay still ends after one cycle.
    assign cnt_nx = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        frames_d   = frames_q;
        phases_d   = phases_q;
        frame_d    = frame_q;
        phase_d    = phase_q;
        on_d       = on_q;
        off_d      = off_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        upd_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    frames_d = req_frames;
                    phases_d = req_phases;
                    on_d     = pwr_on_dly;
                    off_d    = pwr_off_dly;
                    gap_d    = frame_gap;
                    tmo_d    = frame_timeout;
                    err_d    = 1'b0;
                    if (req_frames == 8'd0 || req_phases == 4'd0) begin
                        upd_done_d = 1'b1;
                    end else begin
                        frame_d = 8'd0;
                        phase_d = 4'd0;
                        state_d = PWR_UP;
                    end
                end
            end
            PWR_UP: begin
                if (abort)                          state_d = PWR_DOWN;
                else if (cnt_nx >= {1'b0, on_q})    state_d = START;
            end
            START: begin
                state_d = abort ? PWR_DOWN : WAIT_DONE;
            end
            WAIT_DONE: begin
                // Priority: abort, then frame_done, then watchdog expiry.
                if (abort) begin
                    state_d = PWR_DOWN;
                end else if (frame_done) begin
                    state_d = GAP;
                end else if (tmo_q != '0 && cnt_nx >= {1'b0, tmo_q}) begin
                    err_d   = 1'b1;
                    state_d = PWR_DOWN;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = PWR_DOWN;
                end else if (cnt_nx >= {1'b0, gap_q}) begin
                    if (frame_q != frames_q - 8'd1) begin
                        frame_d = frame_q + 8'd1;
                        state_d = START;
                    end else if (phase_q != phases_q - 4'd1) begin
                        frame_d = 8'd0;
                        phase_d = phase_q + 4'd1;
                        state_d = START;
                    end else begin
                        state_d = PWR_DOWN;
                    end
                end
            end
            PWR_DOWN: begin
                if (cnt_nx >= {1'b0, off_q}) begin
                    state_d    = IDLE;
                    upd_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            frames_q      <= '0;
            phases_q      <= '0;
            frame_q       <= '0;
            phase_q       <= '0;
            on_q          <= '0;
            off_q         <= '0;
            gap_q         <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            upd_done_q    <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            pwr_en_q      <= 1'b0;
            frame_fresh_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frames_q      <= frames_d;
            phases_q      <= phases_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            on_q          <= on_d;
            off_q         <= off_d;
            gap_q         <= gap_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            upd_done_q    <= upd_done_d;
            req_ready_q   <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            pwr_en_q      <= (state_d == PWR_UP) || (state_d == START) ||
                             (state_d == WAIT_DONE) || (state_d == GAP);
            frame_fresh_q <= (state_d == START);
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign pwr_en      = pwr_en_q;
    assign frame_fresh = frame_fresh_q;
    assign upd_done    = upd_done_q;
    assign err         = err_q;
    assign phase_idx   = phase_q;
    assign frame_idx   = frame_q;

endmodule

// File: tb/tb_eink_frame_sched.sv
// tb/tb_eink_frame_sched.sv - scoreboard bench for eink_frame_sched
module tb_eink_frame_sched;
    localparam int CNT_W   = 16;
    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_FRESH = 2;
    localparam int K_DONE  = 3;

    logic             clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
    logic             abort = 1'b0, frame_done = 1'b0;
    logic [7:0]       req_frames = '0;
    logic [3:0]       req_phases = '0;
    logic [CNT_W-1:0] pwr_on_dly = '0, pwr_off_dly = '0, frame_gap = '0, frame_timeout = '0;
    logic             req_ready, frame_fresh, pwr_en, busy, upd_done, err;
    logic [3:0]       phase_idx;
    logic [7:0]       frame_idx;

    eink_frame_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_frames(req_frames), .req_phases(req_phases),
        .pwr_on_dly(pwr_on_dly), .pwr_off_dly(pwr_off_dly),
        .frame_gap(frame_gap), .frame_timeout(frame_timeout),
        .abort(abort), .frame_done(frame_done), .frame_fresh(frame_fresh),
        .pwr_en(pwr_en), .phase_idx(phase_idx), .frame_idx(frame_idx),
        .busy(busy), .upd_done(upd_done), .err(err)
    );

    typedef struct {
        int kind;
        int cyc;
        int ph;
        int fr;
        int er;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0, bad = 0, cyc = 0;
    int  d_arr[16];
    bit  sp_arr[16];
    int  fcnt = 0;
    int  f_edge = -1000, f_cur = 0;
    bit  pwr_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int max1(int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic push(int kind, int c, int ph, int fr, int er);
        ev_t e;
        e.kind = kind; e.cyc = c; e.ph = ph; e.fr = fr; e.er = er;
        exp_q.push_back(e);
    endtask

    // Panel model: frame k answers frame_done sampled d_arr[k] edges after its fresh edge,
    // plus an optional pulse coincident with the fresh pulse.
    always @(negedge clk) begin
        frame_done = 1'b0;
        if (rst_n && frame_fresh) begin
            f_edge = cyc;
            f_cur  = fcnt;
            fcnt   = fcnt + 1;
        end
        if (f_cur < 16) begin
            if (sp_arr[f_cur] && cyc == f_edge) frame_done = 1'b1;
            if (d_arr[f_cur] != 0 && cyc == f_edge + d_arr[f_cur] - 1) frame_done = 1'b1;
        end
    end

    task automatic mon_ev(int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_FRESH) begin
                chk("fresh_phase_idx", int'(phase_idx), e.ph);
                chk("fresh_frame_idx", int'(frame_idx), e.fr);
                chk("fresh_busy", int'(busy), 1);
            end
            if (kind == K_DONE) begin
                chk("done_err", int'(err), e.er);
                chk("done_pwr_en", int'(pwr_en), 0);
                chk("done_req_ready", int'(req_ready), 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pwr_prev = 1'b0;
        end else begin
            if (pwr_en !== pwr_prev) begin
                mon_ev(pwr_en ? K_RISE : K_FALL);
                pwr_prev = pwr_en;
            end
            if (frame_fresh) mon_ev(K_FRESH);
            if (upd_done)    mon_ev(K_DONE);
        end
    end

    // Reference: edge numbers of every visible event for one request accepted at edge a.
    task automatic model(int a, int nf, int np, int on, int gp, int off, int to,
                         bit ab, int e_ab, output int merr);
        int  t, endc, g, pd, idx;
        bit  tmo, stop;
        merr = 0;
        if (nf == 0 || np == 0) begin
            push(K_DONE, a, 0, 0, 0);
            return;
        end
        push(K_RISE, a, 0, 0, 0);
        t = a + max1(on); pd = a; stop = 0; idx = 0;
        for (int p = 0; p < np && !stop; p++) begin
            for (int f = 0; f < nf && !stop; f++) begin
                if (ab && e_ab <= t) begin
                    pd = e_ab; stop = 1;
                end else begin
                    push(K_FRESH, t, p, f, 0);
                    tmo  = (to != 0) && (d_arr[idx] == 0 || d_arr[idx] > to + 1);
                    endc = tmo ? t + to + 1 : t + d_arr[idx];
                    idx++;
                    if (ab && e_ab <= endc) begin
                        pd = e_ab; stop = 1;
                    end else if (tmo) begin
                        pd = endc; merr = 1; stop = 1;
                    end else begin
                        g = endc + max1(gp);
                        if (ab && e_ab <= g) begin
                            pd = e_ab; stop = 1;
                        end else if (p == np - 1 && f == nf - 1) begin
                            pd = g; stop = 1;
                        end else begin
                            t = g;
                        end
                    end
                end
            end
        end
        push(K_FALL, pd, 0, 0, 0);
        push(K_DONE, pd + max1(off), 0, 0, merr);
    endtask

    task automatic set_d(int d, bit sp);
        for (int i = 0; i < 16; i++) begin
            d_arr[i]  = d;
            sp_arr[i] = sp;
        end
    endtask

    task automatic start_txn(int nf, int np, int on, int gp, int off, int to,
                             bit ab, int erel, output int a, output int merr);
        int n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_request", int'(req_ready), 1);
        a = cyc + 1;
        fcnt = 0;
        req_frames    = 8'(nf);
        req_phases    = 4'(np);
        pwr_on_dly    = CNT_W'(on);
        frame_gap     = CNT_W'(gp);
        pwr_off_dly   = CNT_W'(off);
        frame_timeout = CNT_W'(to);
        req_valid     = 1'b1;
        model(a, nf, np, on, gp, off, to, ab, a + erel, merr);
        @(negedge clk);
        req_valid     = 1'b0;
        req_frames    = 8'($urandom);
        req_phases    = 4'($urandom);
        pwr_on_dly    = CNT_W'($urandom);
        frame_gap     = CNT_W'($urandom);
        pwr_off_dly   = CNT_W'($urandom);
        frame_timeout = CNT_W'($urandom_range(1, 3));
    endtask

    task automatic finish_txn(bit ab, int e_ab, int merr);
        int n = 0;
        while ((exp_q.size() != 0 || (ab && cyc < e_ab)) && n < 3000) begin
            abort = ab && (cyc == e_ab - 1);
            @(negedge clk);
            n++;
        end
        abort = 1'b0;
        chk("events_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("err_sticky", int'(err), merr);
        chk("idle_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic run_txn(int nf, int np, int on, int gp, int off, int to, bit ab, int erel);
        int a, merr;
        start_txn(nf, np, on, gp, off, to, ab, erel, a, merr);
        finish_txn(ab, a + erel, merr);
    endtask

    initial begin
        int a, merr, nf, np, to;
        set_d(2, 1'b0);
        @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pwr_en", int'(pwr_en), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_phase_idx", int'(phase_idx), 0);
        chk("reset_frame_idx", int'(frame_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_d(50, 1'b0);
        run_txn(2, 3, 10, 4, 8, 0, 1'b0, 0);
        set_d(0, 1'b0);
        run_txn(2, 2, 5, 3, 4, 20, 1'b0, 0);
        run_txn(0, 3, 5, 3, 4, 0, 1'b0, 0);
        run_txn(2, 0, 5, 3, 4, 0, 1'b0, 0);
        set_d(10, 1'b0);
        run_txn(3, 2, 5, 6, 7, 0, 1'b1, 33);
        set_d(3, 1'b1);
        run_txn(1, 1, 0, 0, 0, 0, 1'b0, 0);
        set_d(6, 1'b0);
        run_txn(1, 1, 2, 2, 2, 5, 1'b0, 0);
        set_d(7, 1'b0);
        run_txn(1, 1, 2, 2, 2, 5, 1'b0, 0);

        set_d(50, 1'b0);
        start_txn(2, 2, 3, 2, 2, 0, 1'b0, 0, a, merr);
        while (cyc < a + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", int'(req_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_pwr_en", int'(pwr_en), 0);
        chk("async_rst_frame_fresh", int'(frame_fresh), 0);
        chk("async_rst_upd_done", int'(upd_done), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_phase_idx", int'(phase_idx), 0);
        chk("async_rst_frame_idx", int'(frame_idx), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        set_d(4, 1'b0);
        run_txn(2, 1, 1, 1, 1, 0, 1'b0, 0);

        for (int r = 0; r < 30; r++) begin
            nf = $urandom_range(1, 3);
            np = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) nf = 0; else np = 0;
            end
            to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 12);
            for (int i = 0; i < 16; i++) begin
                sp_arr[i] = ($urandom_range(0, 3) == 0);
                if (to != 0 && $urandom_range(0, 4) == 0) d_arr[i] = 0;
                else d_arr[i] = $urandom_range(2, 16);
            end
            run_txn(nf, np, $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 6),
                    to, ($urandom_range(0, 3) == 0), $urandom_range(1, 60));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
